systolic_tile_seq: RTL and testbench
====================================

SYSTOLIC_TILE_SEQ -- requirements
Module: systolic_tile_seq

Interface
REQ-001 Parameter N, default 4, array dimension (rows = columns = lanes); legal range 2..16.
REQ-002 Parameter DATA_WIDTH, default 8, operand width in bits.
REQ-003 Parameter ACC_WIDTH, default 32, accumulator and bias width in bits.
REQ-004 Parameter KMAX, default 16, maximum beats per tile.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset, with ports as follows.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  begin tile; sampled only in IDLE.
- k_len  in  $clog2(KMAX+1)  beats in this tile; sampled with start.
- bias_in  in  N*ACC_WIDTH  per-column bias, lane j at [j*ACC_WIDTH +: ACC_WIDTH]; sampled with start.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- a_row  in  N*DATA_WIDTH  A column-slice, lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- b_col  in  N*DATA_WIDTH  B row-slice, same lane packing.
- arr_load_bias  out  1  array bias-load strobe.
- arr_bias  out  N*ACC_WIDTH  bias to array.
- arr_a  out  N*DATA_WIDTH  skewed A lanes to array.
- arr_b  out  N*DATA_WIDTH  skewed B lanes to array.
- arr_out  in  N*N*ACC_WIDTH  array accumulators, PE(i,j) at [(i*N+j)*ACC_WIDTH +: ACC_WIDTH].
- out_valid  out  1  tile result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_tile  out  N*N*ACC_WIDTH  captured result, same packing as arr_out.
- busy  out  1  high in any state other than IDLE.
- err_klen  out  1  one-cycle pulse on a rejected start.

Function
REQ-006 The FSM SHALL have the states IDLE, BIAS, FEED, FLUSH, CAPTURE and HOLD.
REQ-007 IDLE: a start with 1 <= k_len <= KMAX SHALL latch k_len and bias_in and go to BIAS.
REQ-008 A start with k_len == 0 or k_len > KMAX SHALL pulse err_klen for one cycle and stay in IDLE.
REQ-009 BIAS SHALL last exactly one cycle, with arr_load_bias = 1 and arr_bias = the latched bias, then go to FEED.
REQ-010 In FEED, in_ready SHALL be 1; in_ready SHALL be 0 in every other state.
REQ-011 Each accepted beat SHALL decrement a beat counter; on the beat that reaches zero, the FSM SHALL go to FLUSH.
REQ-012 Lane i of arr_a and of arr_b SHALL be the input lane i delayed by exactly i cycles (lane 0 has no delay), through per-lane shift registers that shift every cycle.
REQ-013 In any cycle with no accepted beat (bubble, or a non-FEED state), zeros SHALL be injected at the head of every lane.
REQ-014 FLUSH SHALL last FLUSH_CYC = 2N-1 cycles, then go to CAPTURE.
REQ-015 CAPTURE SHALL register arr_out into out_tile in one cycle and go to HOLD.
REQ-016 HOLD SHALL assert out_valid and keep out_tile stable until out_ready; on that handshake cycle the FSM SHALL go to IDLE.
REQ-017 Accumulation arithmetic belongs to the array; this block SHALL NOT modify values and SHALL pass widths unchanged.
REQ-018 start outside IDLE SHALL be ignored, with no err_klen pulse.
REQ-019 A new start SHALL be accepted in the cycle after the HOLD handshake, which gives a minimum tile period of k_len + 2N + 3 cycles.

Reset
REQ-020 On rst low, the FSM SHALL go to IDLE, all skew registers, out_tile and the counters SHALL clear to 0, and every output SHALL be 0.
REQ-021 Reset asserted mid-tile SHALL abandon the tile with no out_valid; after release, the first start SHALL behave as after power-up.

Structure
REQ-022 A shared package SHALL hold the state enum type and the FLUSH_CYC and counter-width derivation functions.
REQ-023 A single sub-module skew_line (parameters DEPTH and DATA_WIDTH, zero-reset shift register) SHALL be instantiated 2N times, with DEPTH = lane index; DEPTH 0 is a wire.

Verification
REQ-024 N=4, bias={1,2,3,4}, k_len=4, A = identity, B = ones, no bubbles -> out_tile(i,j) = 1 + bias_j, against a reference-model array; out_valid at cycle start + 4 + 2N + 2.
REQ-025 Same tile with in_valid low on alternate cycles -> identical out_tile; arr_a lane 3 equals a_row lane 3 from 3 cycles earlier.
REQ-026 k_len=0 and k_len=KMAX+1 -> err_klen pulses once each, busy stays 0, and no arr_load_bias.
REQ-027 out_ready held low for 10 cycles in HOLD -> out_valid and out_tile stable; a start pulse during HOLD is ignored.
REQ-028 rst low during FEED after 2 beats -> all outputs 0; a following clean tile gives the correct result.
REQ-029 k_len=KMAX with all operands 8'hFF -> accumulators match the model for all PEs, with no lost beats.

Source files
------------

// File: rtl/systolic_tile_seq_pkg.sv
// Shared definitions for the systolic tile sequencer.
//   state_e   : sequencer FSM states
//   flush_cyc : drain cycles needed for the last beat to cross an N x N array
//   cnt_width : bits needed to hold a count of 0..max_val
package systolic_tile_seq_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StBias,
      StFeed,
      StFlush,
      StCapture,
      StHold
   } state_e;

   // The last beat enters lane N-1 with N-1 cycles of skew and then crosses
   // N-1 PEs, so 2N-1 drain cycles cover it with one cycle of margin.
   function automatic int unsigned flush_cyc(input int unsigned n);
      return 2 * n - 1;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/systolic_tile_seq_if.sv
// Bundle of the tile sequencer's data/handshake signals.
//   slave  : sequencer view (receives host beats and array results)
//   master : environment view (host plus the PE array)
// Signals: start/k_len/bias_in (tile setup), in_valid/in_ready/a_row/b_col
// (beat stream), arr_load_bias/arr_bias/arr_a/arr_b/arr_out (array side),
// out_valid/out_ready/out_tile (result), busy, err_klen (status).
interface systolic_tile_seq_if #(
   parameter int unsigned N          = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ACC_WIDTH  = 32,
   parameter int unsigned KMAX       = 16
);
   import systolic_tile_seq_pkg::*;

   localparam int unsigned KW = cnt_width(KMAX);

   logic                        start;
   logic [KW-1:0]               k_len;
   logic [N*ACC_WIDTH-1:0]      bias_in;
   logic                        in_valid;
   logic                        in_ready;
   logic [N*DATA_WIDTH-1:0]     a_row;
   logic [N*DATA_WIDTH-1:0]     b_col;
   logic                        arr_load_bias;
   logic [N*ACC_WIDTH-1:0]      arr_bias;
   logic [N*DATA_WIDTH-1:0]     arr_a;
   logic [N*DATA_WIDTH-1:0]     arr_b;
   logic [N*N*ACC_WIDTH-1:0]    arr_out;
   logic                        out_valid;
   logic                        out_ready;
   logic [N*N*ACC_WIDTH-1:0]    out_tile;
   logic                        busy;
   logic                        err_klen;

   modport slave (
      input  start, k_len, bias_in, in_valid, a_row, b_col, arr_out, out_ready,
      output in_ready, arr_load_bias, arr_bias, arr_a, arr_b, out_valid, out_tile,
             busy, err_klen
   );

   modport master (
      output start, k_len, bias_in, in_valid, a_row, b_col, arr_out, out_ready,
      input  in_ready, arr_load_bias, arr_bias, arr_a, arr_b, out_valid, out_tile,
             busy, err_klen
   );

endinterface

// File: rtl/systolic_tile_seq_skew_line.sv
// Zero-reset shift register delaying one lane by DEPTH cycles.
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-low
//   din  : lane input
//   dout : din delayed by DEPTH cycles (DEPTH 0 is a plain wire)
module skew_line #(
   parameter int unsigned DEPTH      = 1,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign dout = din;
   end else begin : g_reg
      logic [DEPTH-1:0][DATA_WIDTH-1:0] sr_q;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            sr_q <= '0;
         end else begin
            sr_q[0] <= din;
            for (int k = 1; k < DEPTH; k++) begin
               sr_q[k] <= sr_q[k-1];
            end
         end
      end

      assign dout = sr_q[DEPTH-1];
   end

endmodule

// File: rtl/systolic_tile_seq.sv
// Sequencer for one output-stationary N x N systolic tile.
// Loads per-column bias into the array, streams k_len beats of A/B slices
// through per-lane skew lines, drains the array, captures the accumulators
// and holds them until the consumer takes them.
//   clk, rst   : clock and asynchronous active-low reset
//   bus.start/k_len/bias_in           : tile setup, sampled in IDLE only
//   bus.in_valid/in_ready/a_row/b_col : beat stream (ready only in FEED)
//   bus.arr_load_bias/arr_bias        : one-cycle bias load into the array
//   bus.arr_a/arr_b                   : skewed lanes to the array
//   bus.arr_out                       : array accumulators
//   bus.out_valid/out_ready/out_tile  : captured result handshake
//   bus.busy, bus.err_klen            : not-idle flag, bad-length pulse
module systolic_tile_seq
   import systolic_tile_seq_pkg::*;
#(
   parameter int unsigned N          = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ACC_WIDTH  = 32,
   parameter int unsigned KMAX       = 16
) (
   input logic               clk,
   input logic               rst,
   systolic_tile_seq_if.slave bus
);

   localparam int unsigned KW       = cnt_width(KMAX);
   localparam int unsigned FlushCyc = flush_cyc(N);
   localparam int unsigned FW       = cnt_width(FlushCyc - 1);

   state_e                   state_q;
   logic [KW-1:0]            beat_cnt_q;
   logic [FW-1:0]            flush_cnt_q;
   logic [N*ACC_WIDTH-1:0]   bias_q;
   logic [N*N*ACC_WIDTH-1:0] out_tile_q;
   logic                     in_ready_q;
   logic                     load_bias_q;
   logic                     out_valid_q;
   logic                     busy_q;
   logic                     err_klen_q;

   logic                     accept;
   logic                     k_len_ok;
   logic [N*DATA_WIDTH-1:0]  a_head;
   logic [N*DATA_WIDTH-1:0]  b_head;
   logic [N*DATA_WIDTH-1:0]  arr_a_w;
   logic [N*DATA_WIDTH-1:0]  arr_b_w;

   // in_ready_q is only ever high in FEED, so this is the beat handshake.
   assign accept   = bus.in_valid & in_ready_q;
   assign k_len_ok = (bus.k_len != '0) && (32'(bus.k_len) <= KMAX);

   // Bubbles and non-FEED cycles push zeros so the array never sees stale data.
   assign a_head = accept ? bus.a_row : '0;
   assign b_head = accept ? bus.b_col : '0;

   for (genvar i = 0; i < N; i++) begin : g_lane
      skew_line #(
         .DEPTH      (i),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_skew_a (
         .clk  (clk),
         .rst  (rst),
         .din  (a_head[i*DATA_WIDTH +: DATA_WIDTH]),
         .dout (arr_a_w[i*DATA_WIDTH +: DATA_WIDTH])
      );

      skew_line #(
         .DEPTH      (i),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_skew_b (
         .clk  (clk),
         .rst  (rst),
         .din  (b_head[i*DATA_WIDTH +: DATA_WIDTH]),
         .dout (arr_b_w[i*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   // Single-process FSM; every output is a register updated on the transition
   // into the state that owns it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         beat_cnt_q  <= '0;
         flush_cnt_q <= '0;
         bias_q      <= '0;
         out_tile_q  <= '0;
         in_ready_q  <= 1'b0;
         load_bias_q <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         err_klen_q  <= 1'b0;
      end else begin
         err_klen_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  if (k_len_ok) begin
                     state_q     <= StBias;
                     beat_cnt_q  <= bus.k_len;
                     bias_q      <= bus.bias_in;
                     load_bias_q <= 1'b1;
                     busy_q      <= 1'b1;
                  end else begin
                     err_klen_q <= 1'b1;
                  end
               end
            end
            StBias: begin
               state_q     <= StFeed;
               load_bias_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
            StFeed: begin
               if (accept) begin
                  beat_cnt_q <= beat_cnt_q - KW'(1);
                  if (beat_cnt_q == KW'(1)) begin
                     state_q     <= StFlush;
                     in_ready_q  <= 1'b0;
                     flush_cnt_q <= FW'(FlushCyc - 1);
                  end
               end
            end
            StFlush: begin
               if (flush_cnt_q == '0) begin
                  state_q <= StCapture;
               end else begin
                  flush_cnt_q <= flush_cnt_q - FW'(1);
               end
            end
            StCapture: begin
               out_tile_q  <= bus.arr_out;
               out_valid_q <= 1'b1;
               state_q     <= StHold;
            end
            StHold: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.in_ready      = in_ready_q;
   assign bus.arr_load_bias = load_bias_q;
   assign bus.arr_bias      = bias_q;
   assign bus.arr_a         = arr_a_w;
   assign bus.arr_b         = arr_b_w;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_tile      = out_tile_q;
   assign bus.busy          = busy_q;
   assign bus.err_klen      = err_klen_q;

endmodule

// File: tb/tb_systolic_tile_seq.sv
// Self-checking bench: a behavioural PE array drives arr_out, a matrix-product
// model gives the expected tile, and a per-cycle monitor checks lane skew and
// result stability.
module tb_systolic_tile_seq;

   localparam int N    = 4;
   localparam int DW   = 8;
   localparam int AW   = 32;
   localparam int KMAX = 16;
   localparam int KW   = $clog2(KMAX + 1);
   localparam int TW   = N * N * AW;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   systolic_tile_seq_if #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .KMAX(KMAX)) ifc ();

   systolic_tile_seq #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .KMAX(KMAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   // Behavioural output-stationary array: A moves right, B moves down.
   logic [AW-1:0] acc_m [N][N];
   logic [DW-1:0] ah    [N][N];
   logic [DW-1:0] bv    [N][N];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               acc_m[i][j] <= '0;
               ah[i][j]    <= '0;
               bv[i][j]    <= '0;
            end
      end else begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               logic [DW-1:0] ai, bi;
               ai = (j == 0) ? ifc.arr_a[i*DW +: DW] : ah[i][(j == 0) ? 0 : j-1];
               bi = (i == 0) ? ifc.arr_b[j*DW +: DW] : bv[(i == 0) ? 0 : i-1][j];
               ah[i][j] <= ai;
               bv[i][j] <= bi;
               if (ifc.arr_load_bias) acc_m[i][j] <= ifc.arr_bias[j*AW +: AW];
               else acc_m[i][j] <= acc_m[i][j] + AW'(ai) * AW'(bi);
            end
      end
   end

   always_comb begin
      ifc.arr_out = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            ifc.arr_out[(i*N+j)*AW +: AW] = acc_m[i][j];
   end

   // Reference tile: beat k carries column k of A (lane i = A[i][k]) and
   // row k of B (lane j = B[k][j]); result = bias_j + sum_k A[i][k]*B[k][j].
   logic [DW-1:0]     ta   [KMAX][N];
   logic [DW-1:0]     tbm  [KMAX][N];
   logic [AW-1:0]     tbias[N];
   logic [AW-1:0]     exp_m[N][N];
   logic [N*AW-1:0]   bias_vec;

   task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic compute_expected(input int k);
      for (int j = 0; j < N; j++) bias_vec[j*AW +: AW] = tbias[j];
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            logic [AW-1:0] s;
            s = tbias[j];
            for (int b = 0; b < k; b++) s += AW'(ta[b][i]) * AW'(tbm[b][j]);
            exp_m[i][j] = s;
         end
   endtask

   task automatic fill_tile(input int kind);
      for (int b = 0; b < KMAX; b++)
         for (int i = 0; i < N; i++) begin
            case (kind)
               0: begin ta[b][i] = (b == i) ? 8'd1 : 8'd0; tbm[b][i] = 8'd1; end
               1: begin ta[b][i] = DW'($urandom); tbm[b][i] = DW'($urandom); end
               default: begin ta[b][i] = 8'hFF; tbm[b][i] = 8'hFF; end
            endcase
         end
      for (int j = 0; j < N; j++)
         tbias[j] = (kind == 0) ? AW'(j + 1) : (kind == 1) ? AW'($urandom) : '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_in_ready"}, TW'(ifc.in_ready), '0);
      chk({tag, "_load_bias"}, TW'(ifc.arr_load_bias), '0);
      chk({tag, "_arr_bias"}, TW'(ifc.arr_bias), '0);
      chk({tag, "_arr_a"}, TW'(ifc.arr_a), '0);
      chk({tag, "_arr_b"}, TW'(ifc.arr_b), '0);
      chk({tag, "_out_valid"}, TW'(ifc.out_valid), '0);
      chk({tag, "_out_tile"}, ifc.out_tile, '0);
      chk({tag, "_busy"}, TW'(ifc.busy), '0);
      chk({tag, "_err_klen"}, TW'(ifc.err_klen), '0);
   endtask

   // Caller is 1 time unit after a rising edge; returns likewise, in IDLE.
   task automatic run_tile(input int k, input bit bubbles, input int hold_wait, input bit poke,
                           output int t_start, output int t_valid, output logic [TW-1:0] got);
      int b, n, t_last;
      bit seen;
      compute_expected(k);
      ifc.start   = 1'b1;
      ifc.k_len   = KW'(k);
      ifc.bias_in = bias_vec;
      t_start     = cyc;
      @(negedge clk);
      chk("idle_busy", TW'(ifc.busy), '0);
      chk("idle_out_valid", TW'(ifc.out_valid), '0);
      tick();
      ifc.start   = 1'b0;
      ifc.bias_in = '0;
      @(negedge clk);
      chk("bias_strobe", TW'(ifc.arr_load_bias), TW'(1));
      chk("bias_value", TW'(ifc.arr_bias), TW'(bias_vec));
      chk("bias_in_ready", TW'(ifc.in_ready), '0);
      b = 0; n = 0; t_last = 0;
      while (b < k && n < 4 * KMAX + 8) begin
         tick();
         ifc.in_valid = bubbles ? (n % 2 == 1) : 1'b1;
         for (int i = 0; i < N; i++) begin
            ifc.a_row[i*DW +: DW] = ifc.in_valid ? ta[b][i]  : DW'($urandom);
            ifc.b_col[i*DW +: DW] = ifc.in_valid ? tbm[b][i] : DW'($urandom);
         end
         @(negedge clk);
         chk("feed_in_ready", TW'(ifc.in_ready), TW'(1));
         if (ifc.in_valid && ifc.in_ready) begin
            b++;
            t_last = cyc;
         end
         n++;
      end
      if (b < k) chk("feed_timeout", TW'(b), TW'(k));
      tick();
      ifc.in_valid = 1'b0;
      seen = 1'b0; n = 0; t_valid = -1;
      while (!seen && n < 4 * N + 8) begin
         @(negedge clk);
         if (ifc.out_valid) begin
            seen    = 1'b1;
            t_valid = cyc;
         end else begin
            chk("flush_in_ready", TW'(ifc.in_ready), '0);
            chk("flush_busy", TW'(ifc.busy), TW'(1));
            tick();
         end
         n++;
      end
      chk("valid_latency", TW'(t_valid), TW'(t_last + 2 * N + 1));
      got = ifc.out_tile;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            chk("tile_pe", TW'(got[(i*N+j)*AW +: AW]), TW'(exp_m[i][j]));
      for (int h = 0; h < hold_wait; h++) begin
         tick();
         ifc.start = poke && (h == 2);
         ifc.k_len = KW'(2);
         @(negedge clk);
         chk("hold_valid", TW'(ifc.out_valid), TW'(1));
         chk("hold_tile", ifc.out_tile, got);
         chk("hold_no_err", TW'(ifc.err_klen), '0);
      end
      tick();
      ifc.start     = 1'b0;
      ifc.out_ready = 1'b1;
      @(negedge clk);
      chk("handshake_valid", TW'(ifc.out_valid), TW'(1));
      tick();
      ifc.out_ready = 1'b0;
   endtask

   // Per-cycle monitor: skew delay, busy coverage and HOLD stability.
   logic [N*DW-1:0] ha [N];
   logic [N*DW-1:0] hb [N];
   logic            prev_valid = 1'b0;
   logic            prev_ready = 1'b0;
   logic [TW-1:0]   prev_tile  = '0;

   always @(negedge clk) begin
      logic [N*DW-1:0] expa, expb;
      if (!rst) begin
         for (int i = 0; i < N; i++) begin ha[i] = '0; hb[i] = '0; end
         prev_valid = 1'b0;
      end else begin
         for (int i = N - 1; i > 0; i--) begin ha[i] = ha[i-1]; hb[i] = hb[i-1]; end
         ha[0] = (ifc.in_valid && ifc.in_ready) ? ifc.a_row : '0;
         hb[0] = (ifc.in_valid && ifc.in_ready) ? ifc.b_col : '0;
         for (int i = 0; i < N; i++) begin
            expa[i*DW +: DW] = ha[i][i*DW +: DW];
            expb[i*DW +: DW] = hb[i][i*DW +: DW];
         end
         chk("skew_a", TW'(ifc.arr_a), TW'(expa));
         chk("skew_b", TW'(ifc.arr_b), TW'(expb));
         if (ifc.in_ready || ifc.out_valid || ifc.arr_load_bias)
            chk("busy_cover", TW'(ifc.busy), TW'(1));
         if (prev_valid && !prev_ready) begin
            chk("stable_valid", TW'(ifc.out_valid), TW'(1));
            chk("stable_tile", ifc.out_tile, prev_tile);
         end
         prev_valid = ifc.out_valid;
         prev_ready = ifc.out_ready;
         prev_tile  = ifc.out_tile;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int ts, tv;
      logic [TW-1:0] got;
      ifc.start = 0; ifc.k_len = '0; ifc.bias_in = '0; ifc.in_valid = 0;
      ifc.a_row = '0; ifc.b_col = '0; ifc.out_ready = 0;
      #3;
      chk_all_zero("por");
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      tick();

      // Identity A, all-ones B, bias 1..4: every PE = 1 + bias_j.
      fill_tile(0);
      run_tile(4, 1'b0, 0, 1'b0, ts, tv, got);
      chk("lat_formula", TW'(tv), TW'(ts + 4 + 2 * N + 2));
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            chk("lit_model", TW'(exp_m[i][j]), TW'(j + 2));
            chk("lit_dut", TW'(got[(i*N+j)*AW +: AW]), TW'(j + 2));
         end

      // Same tile with alternate bubbles.
      run_tile(4, 1'b1, 0, 1'b0, ts, tv, got);
      for (int j = 0; j < N; j++) chk("lit_bubble", TW'(got[(N+j)*AW +: AW]), TW'(j + 2));

      // Rejected lengths.
      for (int e = 0; e < 2; e++) begin
         ifc.start = 1'b1;
         ifc.k_len = (e == 0) ? KW'(0) : KW'(KMAX + 1);
         @(negedge clk);
         chk("err_pre", TW'(ifc.err_klen), '0);
         tick();
         ifc.start = 1'b0;
         @(negedge clk);
         chk("err_pulse", TW'(ifc.err_klen), TW'(1));
         chk("err_busy", TW'(ifc.busy), '0);
         chk("err_no_bias", TW'(ifc.arr_load_bias), '0);
         tick();
         @(negedge clk);
         chk("err_once", TW'(ifc.err_klen), '0);
         chk("err_busy2", TW'(ifc.busy), '0);
         tick();
      end

      // Long HOLD with a start poke.
      fill_tile(1);
      run_tile(int'($urandom_range(KMAX, 1)), 1'b0, 10, 1'b1, ts, tv, got);

      // Reset during FEED after two beats.
      fill_tile(1);
      ifc.start = 1'b1; ifc.k_len = KW'(4);
      tick(); ifc.start = 1'b0;
      tick(); ifc.in_valid = 1'b1; ifc.a_row = '1; ifc.b_col = '1;
      tick();
      tick(); ifc.in_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk_all_zero("midrst");
      tick(); tick();
      rst = 1'b1;
      tick();
      @(negedge clk);
      chk("post_rst_busy", TW'(ifc.busy), '0);
      tick();
      fill_tile(0);
      run_tile(4, 1'b0, 2, 1'b0, ts, tv, got);
      for (int j = 0; j < N; j++) chk("lit_after_rst", TW'(got[(2*N+j)*AW +: AW]), TW'(j + 2));

      // Full-length tile of 8'hFF operands: 16 * 255 * 255 per PE.
      fill_tile(2);
      run_tile(KMAX, 1'b1, 1, 1'b0, ts, tv, got);
      chk("lit_ff_model", TW'(exp_m[3][1]), TW'(1040400));
      chk("lit_ff_dut", TW'(got[(3*N+3)*AW +: AW]), TW'(1040400));

      // Back-to-back random tiles.
      for (int r = 0; r < 6; r++) begin
         fill_tile(1);
         run_tile(int'($urandom_range(KMAX, 1)), 1'($urandom), int'($urandom_range(3, 0)),
                  1'b0, ts, tv, got);
      end

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
